// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the redirect controller: redirect causes and controller states.
package p_hardisc;

  typedef enum logic [2:0] {
    RC_BOOT   = 3'd0,
    RC_RSTPP  = 3'd1,
    RC_EXC    = 3'd2,
    RC_MRET   = 3'd3,
    RC_INT    = 3'd4,
    RC_MAXRST = 3'd5
  } red_cause;

  typedef enum logic [1:0] {
    RDS_BOOT = 2'd0,
    RDS_IDLE = 2'd1,
    RDS_PEND = 2'd2
  } red_state;

endpackage

// File: rtl/redirect_ctrl_if.sv
// Redirect handshake towards fetch: controller drives valid/addr/cause, fetch returns ready.
interface redirect_ctrl_if;
  logic                s_red_valid_o;
  logic [31:0]         s_red_addr_o;
  p_hardisc::red_cause s_red_cause_o;
  logic                s_red_ready_i;

  modport master (output s_red_valid_o, output s_red_addr_o, output s_red_cause_o,
                  input  s_red_ready_i);
  modport slave  (input  s_red_valid_o, input  s_red_addr_o, input  s_red_cause_o,
                  output s_red_ready_i);
endinterface

// File: rtl/redirect_ctrl_seu_regs.sv
// Labelled state register with asynchronous active-low reset to a fixed value.
module seu_regs #(
  parameter string        LABEL   = "",
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         s_clk_i,
  input  logic         s_resetn_i,
  input  logic [W-1:0] s_d_i,
  output logic [W-1:0] s_q_o
);
  logic [W-1:0] data_q;

  // The label names the register for fault-injection tooling; a missing one is kept visible here.
  if (LABEL == "") begin : g_unlabeled
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) data_q <= RST_VAL;
    else             data_q <= s_d_i;
  end

  assign s_q_o = data_q;
endmodule

// File: rtl/redirect_ctrl.sv
// Arbitrates CSR redirect events, registers the winning target and hands it to fetch;
// counts consecutive pipeline restarts and escalates to a boot restart at the limit.
module redirect_ctrl
  import p_hardisc::*;
#(
  parameter int RST_LIMIT = 4,
  parameter int CNT_W     = $clog2(RST_LIMIT + 1)
) (
  input  logic                   s_clk_i,
  input  logic                   s_resetn_i,
  input  logic [31:0]            s_boot_add_i,
  input  logic                   s_exception_i,
  input  logic [31:0]            s_exc_trap_i,
  input  logic                   s_int_pending_i,
  input  logic [31:0]            s_int_trap_i,
  input  logic                   s_treturn_i,
  input  logic [31:0]            s_mepc_i,
  input  logic                   s_rstpp_i,
  input  logic [31:0]            s_rst_point_i,
  input  logic                   s_hrdmax_rst_i,
  input  logic                   s_retired_i,
  redirect_ctrl_if.master        s_red,
  output logic                   s_interrupted_o,
  output logic                   s_flush_o,
  output logic                   s_stall_o,
  output logic                   s_maxrst_o
);
  logic [1:0]       state_raw_q;
  logic [2:0]       cause_raw_q;
  red_state         state_q, state_d;
  red_cause         cause_q, cause_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             idle, cap_rstpp, cap_exc, cap_tret, cap_int, cap_any, escalate;

  assign state_q = red_state'(state_raw_q);
  assign cause_q = red_cause'(cause_raw_q);

  seu_regs #(.LABEL("RED_STATE"), .W(2), .RST_VAL(RDS_BOOT)) u_state (
    .s_clk_i, .s_resetn_i, .s_d_i(state_d), .s_q_o(state_raw_q));
  seu_regs #(.LABEL("RED_ADDR"), .W(32), .RST_VAL(32'h0)) u_addr (
    .s_clk_i, .s_resetn_i, .s_d_i(addr_d), .s_q_o(addr_q));
  seu_regs #(.LABEL("RED_CAUSE"), .W(3), .RST_VAL(RC_BOOT)) u_cause (
    .s_clk_i, .s_resetn_i, .s_d_i(cause_d), .s_q_o(cause_raw_q));
  seu_regs #(.LABEL("RED_RSTCNT"), .W(CNT_W), .RST_VAL('0)) u_cnt (
    .s_clk_i, .s_resetn_i, .s_d_i(cnt_d), .s_q_o(cnt_q));

  // Fixed priority: restart > exception > trap return > interrupt, only while idle.
  assign idle      = (state_q == RDS_IDLE);
  assign cap_rstpp = idle & s_rstpp_i;
  assign cap_exc   = idle & ~s_rstpp_i & s_exception_i;
  assign cap_tret  = idle & ~s_rstpp_i & ~s_exception_i & s_treturn_i;
  assign cap_int   = idle & ~s_rstpp_i & ~s_exception_i & ~s_treturn_i & s_int_pending_i;
  assign cap_any   = cap_rstpp | cap_exc | cap_tret | cap_int;
  assign escalate  = cap_rstpp & s_hrdmax_rst_i & ~s_retired_i &
                     (cnt_q == CNT_W'(RST_LIMIT - 1));

  always_comb begin
    cnt_base = s_retired_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (escalate)
      cnt_d = '0;
    else if (cap_rstpp && (cnt_base != CNT_W'(RST_LIMIT)))
      cnt_d = cnt_base + CNT_W'(1);
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    cause_d             = cause_q;
    s_red.s_red_valid_o = 1'b0;
    s_red.s_red_addr_o  = addr_q;
    s_red.s_red_cause_o = cause_q;
    s_stall_o           = 1'b0;
    s_flush_o           = 1'b0;
    s_interrupted_o     = 1'b0;
    s_maxrst_o          = 1'b0;
    case (state_q)
      RDS_BOOT: begin
        s_red.s_red_valid_o = 1'b1;
        s_red.s_red_addr_o  = s_boot_add_i;
        s_red.s_red_cause_o = RC_BOOT;
        s_stall_o           = 1'b1;
        if (s_red.s_red_ready_i) state_d = RDS_IDLE;
      end
      RDS_IDLE: begin
        s_interrupted_o = cap_int;
        s_maxrst_o      = escalate;
        if (cap_any) begin
          s_flush_o = 1'b1;
          state_d   = RDS_PEND;
          if (escalate) begin
            addr_d  = s_boot_add_i;
            cause_d = RC_MAXRST;
          end else if (cap_rstpp) begin
            addr_d  = s_rst_point_i;
            cause_d = RC_RSTPP;
          end else if (cap_exc) begin
            addr_d  = s_exc_trap_i;
            cause_d = RC_EXC;
          end else if (cap_tret) begin
            addr_d  = s_mepc_i;
            cause_d = RC_MRET;
          end else begin
            addr_d  = s_int_trap_i;
            cause_d = RC_INT;
          end
        end
      end
      RDS_PEND: begin
        s_red.s_red_valid_o = 1'b1;
        s_stall_o           = 1'b1;
        if (s_red.s_red_ready_i) state_d = RDS_IDLE;
      end
      default: state_d = RDS_BOOT;
    endcase
  end
endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Control-flow redirect controller placed directly downstream of the CSR unit in the MA stage. It arbitrates the CSR unit's exception, interrupt, trap-return and pipeline-restart indications and registers the winning target address. It then presents that address to fetch over a valid/ready handshake and returns interrupt approval to the CSR unit. It also counts consecutive pipeline restarts and escalates to a boot-address restart when the limit is reached and hardening control enables it.

## Interface
- RST_LIMIT, 4: consecutive restarts that trigger escalation; legal range 2..15.
- CNT_W, $clog2(RST_LIMIT+1): restart counter width.

Ports (name, direction, width, meaning):
- s_clk_i in 1: clock.
- s_resetn_i in 1: reset, asynchronous, active-low.
- s_boot_add_i in 32: boot address.
- s_exception_i in 1: exception from CSR unit.
- s_exc_trap_i in 32: exception trap-handler address.
- s_int_pending_i in 1: pending enabled interrupt.
- s_int_trap_i in 32: interrupt trap-handler address.
- s_treturn_i in 1: MRET in MA.
- s_mepc_i in 32: MEPC value.
- s_rstpp_i in 1: pipeline restart request.
- s_rst_point_i in 32: reset-point address.
- s_hrdmax_rst_i in 1: escalation enable (hardening control bit).
- s_retired_i in 1: an instruction retired normally.
- s_red_ready_i in 1: fetch accepts redirect.
- s_red_valid_o out 1: redirect valid.
- s_red_addr_o out 32: redirect target.
- s_red_cause_o out 3: red_cause of the pending redirect.
- s_interrupted_o out 1: interrupt approval to CSR unit (combinational).
- s_flush_o out 1: flush of upstream stages (combinational).
- s_stall_o out 1: holds the MA stage while a redirect is pending.
- s_maxrst_o out 1: one-cycle pulse when escalation occurs.

## Operation
- States are BOOT, IDLE and PEND. Reset enters BOOT.
- BOOT:
  - s_red_valid_o=1, addr=s_boot_add_i, cause=RC_BOOT, s_stall_o=1.
  - On handshake, go to IDLE.
- IDLE: capture priority is rstpp > exception > treturn > interrupt.
  - rstpp: target s_rst_point_i, cause RC_RSTPP.
  - exception: target s_exc_trap_i, cause RC_EXC.
  - treturn: target s_mepc_i, cause RC_MRET.
  - interrupt: target s_int_trap_i, cause RC_INT.
  - On any capture: register target and cause, s_flush_o=1 that cycle, next state PEND.
  - s_interrupted_o=1 only in IDLE when an interrupt wins arbitration.
- PEND:
  - s_red_valid_o=1 with the registered addr/cause; s_stall_o=1.
  - Events are not captured, no approval is given, and s_flush_o=0.
  - On s_red_valid_o & s_red_ready_i, go to IDLE.
- Restart counter (CNT_W bits, resets to 0):
  - Updated in every state.
  - s_retired_i clears it first.
  - A captured rstpp then increments it, saturating at RST_LIMIT.
  - Retire and captured rstpp in the same cycle leave the counter at 1.
- Escalation:
  - Condition: captured rstpp, counter==RST_LIMIT-1, s_hrdmax_rst_i=1, and no retire that cycle.
  - Target becomes s_boot_add_i and cause RC_MAXRST.
  - s_maxrst_o pulses in the capture cycle and the counter clears to 0.
- Reset during BOOT or PEND discards the pending redirect and returns to BOOT.

## Timing
- Reset values:
  - s_red_valid_o=1, s_red_addr_o=s_boot_add_i, s_red_cause_o=RC_BOOT, s_stall_o=1.
  - s_interrupted_o=0, s_flush_o=0, s_maxrst_o=0.
- Capture in cycle N gives s_red_valid_o=1 from N+1. The earliest return to IDLE is N+2, with ready=1 at N+1.
- Valid stays asserted and addr/cause stay stable until the handshake; ready may toggle freely.
- After a handshake in cycle M, IDLE can capture a new event in M+1 (back-to-back).
- s_flush_o, s_interrupted_o and s_maxrst_o are single-cycle, valid in the capture cycle only.

## Structure
- Package p_hardisc holds:
  - typedef enum logic[2:0] red_cause: RC_BOOT=0, RC_RSTPP=1, RC_EXC=2, RC_MRET=3, RC_INT=4, RC_MAXRST=5.
  - the state enum {RDS_BOOT, RDS_IDLE, RDS_PEND}.
- State, target, cause and counter registers go through seu_regs with labels RED_STATE, RED_ADDR, RED_CAUSE and RED_RSTCNT.
- No further sub-module.

## Test plan
- Boot handshake:
  - Stimulus: release reset with boot_add=0x8000_0000, ready low 3 cycles, then high.
  - Expected: valid=1 and addr=0x8000_0000 held for 4 cycles, then IDLE.
- Simultaneous events:
  - Stimulus: exception, interrupt and treturn in the same cycle, with exc_trap=0x100, int_trap=0x200, mepc=0x300.
  - Expected: addr=0x100, cause=RC_EXC, interrupted=0, flush=1 for one cycle.
- Lone interrupt:
  - Stimulus: interrupt alone with int_trap=0x204.
  - Expected: interrupted=1 in the capture cycle; valid next cycle with addr=0x204.
- Restart escalation (RST_LIMIT=4, hrdmax=1):
  - Stimulus: 4 rstpp captures with no retire between them.
  - Expected: first three target rst_point; the fourth targets boot_add with RC_MAXRST and a maxrst pulse; counter reads 0.
- Counter clear and escalation disable:
  - Stimulus: 3 rstpp, then retire plus rstpp in the same cycle, then 3 rstpp.
  - Expected: the counter reaches 1 on the combined cycle; escalation fires on the 3rd following rstpp.
  - Stimulus: repeat with hrdmax=0.
  - Expected: no escalation and the counter saturates at 4.
- Reset mid-operation and PEND blocking:
  - Stimulus: reset asserted in PEND.
  - Expected: immediate BOOT and addr=boot_add.
  - Stimulus: events raised during PEND.
  - Expected: ignored until the handshake, and captured in the cycle after it.
